// File: rtl/z_pattern_monitor_pkg.sv
// Shared types and helpers for the z sequence monitor: FSM encoding, default
// pattern geometry and the saturating counter step.
package z_mon_pkg;

    localparam int          DEF_PLEN    = 4;
    localparam logic [15:0] DEF_PATTERN = 16'b1101;
    localparam int          DEF_CW      = 8;

    localparam logic ST_FILLING = 1'b0;
    localparam logic ST_ARMED   = 1'b1;

    typedef enum logic {
        FILLING = ST_FILLING,
        ARMED   = ST_ARMED
    } state_e;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/z_pattern_monitor_if.sv
// Sample/event bus of the z monitor. master = monitor side, slave = the
// upstream sampler plus the event consumer.
interface z_pattern_monitor_if #(
    parameter int CW = 8
);
    logic          z;
    logic          sample_en;
    logic          clear;
    logic          evt_ready;
    logic          match;
    logic [CW-1:0] hit_count;
    logic          evt_valid;
    logic [CW-1:0] evt_count;
    logic          drop_flag;

    modport master (
        input  z, sample_en, clear, evt_ready,
        output match, hit_count, evt_valid, evt_count, drop_flag
    );

    modport slave (
        output z, sample_en, clear, evt_ready,
        input  match, hit_count, evt_valid, evt_count, drop_flag
    );
endinterface

// File: rtl/z_pattern_monitor_evt_slot.sv
// One-entry valid/ready holding register for match events; a push that finds
// the slot full and not draining is dropped and remembered in a sticky flag.
module z_evt_slot #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [CW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [CW-1:0] o_data,
    output logic          o_drop
);

    logic          r_valid;
    logic [CW-1:0] r_data;
    logic          r_drop;
    logic          w_pop;

    assign w_pop = r_valid & i_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else if (i_push) begin
            // A same-cycle pop frees the slot for the new event.
            if (!r_valid || w_pop) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else begin
                r_drop  <= 1'b1;
            end
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_drop  = r_drop;

endmodule

// File: rtl/z_pattern_monitor.sv
// Watches the serial z stream for a PLEN-sample pattern, counts hits
// (saturating) and posts each hit into a single-entry event slot.
module z_pattern_monitor
    import z_mon_pkg::*;
#(
    parameter int              PLEN    = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN),
    parameter int              CW      = DEF_CW,
    parameter int              OVERLAP = 1
) (
    input logic                 clk,
    input logic                 reset,
    z_pattern_monitor_if.master bus
);

    localparam int FW = $clog2(PLEN + 1);

    // Only the newest PLEN-1 samples need storing; z completes the window.
    logic [PLEN-2:0] r_hist;
    logic [FW-1:0]   r_fill;
    logic [FW-1:0]   w_fill_nxt;
    state_e          r_state;
    state_e          w_state_nxt;
    logic [PLEN-1:0] w_win;
    logic            w_full;
    logic            w_hit;
    logic            r_match;
    logic [CW-1:0]   r_hit_count;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_evt_valid;
    logic [CW-1:0]   w_evt_count;
    logic            w_drop;

    assign w_win     = {r_hist, bus.z};
    assign w_full    = (r_state == ARMED) || (r_fill == FW'(PLEN - 1));
    assign w_hit     = bus.sample_en && !bus.clear && w_full && (w_win == PATTERN);
    assign w_cnt_inc = CW'(sat_inc(32'(r_hit_count), CW));

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        if (bus.clear) begin
            w_state_nxt = FILLING;
            w_fill_nxt  = '0;
        end else if (bus.sample_en) begin
            if (w_hit && (OVERLAP == 0)) begin
                w_state_nxt = FILLING;
                w_fill_nxt  = '0;
            end else if (r_state == FILLING) begin
                w_fill_nxt = r_fill + FW'(1);
                if (r_fill == FW'(PLEN - 1)) w_state_nxt = ARMED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FILLING;
            r_fill      <= '0;
            r_hist      <= '0;
            r_match     <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_match <= w_hit;
            if (bus.clear) begin
                r_hist      <= '0;
                r_hit_count <= '0;
            end else begin
                if (bus.sample_en) r_hist      <= w_win[PLEN-2:0];
                if (w_hit)         r_hit_count <= w_cnt_inc;
            end
        end
    end

    z_evt_slot #(.CW(CW)) u_slot (
        .clk     (clk),
        .reset   (reset),
        .i_clear (bus.clear),
        .i_push  (w_hit),
        .i_data  (w_cnt_inc),
        .i_ready (bus.evt_ready),
        .o_valid (w_evt_valid),
        .o_data  (w_evt_count),
        .o_drop  (w_drop)
    );

    assign bus.match     = r_match;
    assign bus.hit_count = r_hit_count;
    assign bus.evt_valid = w_evt_valid;
    assign bus.evt_count = w_evt_count;
    assign bus.drop_flag = w_drop;

endmodule

// File: tb/tb_z_pattern_monitor.sv
// Bench for z_pattern_monitor: three configurations (overlap, no overlap,
// 3-bit counter) share one stimulus and are checked against a queue-based model.
module tb_z_pattern_monitor;

    logic clk = 1'b0;
    logic reset;
    logic t_z, t_se, t_clr, t_rdy;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    z_pattern_monitor_if #(.CW(8)) ifa ();
    z_pattern_monitor_if #(.CW(8)) ifb ();
    z_pattern_monitor_if #(.CW(3)) ifc ();

    assign ifa.z = t_z;  assign ifa.sample_en = t_se;  assign ifa.clear = t_clr;  assign ifa.evt_ready = t_rdy;
    assign ifb.z = t_z;  assign ifb.sample_en = t_se;  assign ifb.clear = t_clr;  assign ifb.evt_ready = t_rdy;
    assign ifc.z = t_z;  assign ifc.sample_en = t_se;  assign ifc.clear = t_clr;  assign ifc.evt_ready = t_rdy;

    z_pattern_monitor #(.PLEN(4), .PATTERN(4'b1101), .CW(8), .OVERLAP(1)) u_ov1 (.clk(clk), .reset(reset), .bus(ifa));
    z_pattern_monitor #(.PLEN(4), .PATTERN(4'b1101), .CW(8), .OVERLAP(0)) u_ov0 (.clk(clk), .reset(reset), .bus(ifb));
    z_pattern_monitor #(.PLEN(4), .PATTERN(4'b1101), .CW(3), .OVERLAP(1)) u_cw3 (.clk(clk), .reset(reset), .bus(ifc));

    // Index 0 = overlap/CW8, 1 = no overlap/CW8, 2 = overlap/CW3.
    logic [2:0] a_match, a_evv, a_drop;
    logic [7:0] a_hit [3];
    logic [7:0] a_evc [3];
    assign a_match = {ifc.match, ifb.match, ifa.match};
    assign a_evv   = {ifc.evt_valid, ifb.evt_valid, ifa.evt_valid};
    assign a_drop  = {ifc.drop_flag, ifb.drop_flag, ifa.drop_flag};
    assign a_hit[0] = ifa.hit_count;  assign a_hit[1] = ifb.hit_count;  assign a_hit[2] = {5'd0, ifc.hit_count};
    assign a_evc[0] = ifa.evt_count;  assign a_evc[1] = ifb.evt_count;  assign a_evc[2] = {5'd0, ifc.evt_count};

    // Reference model: the window is simply the list of samples accepted since
    // the last restart, trimmed to the newest PL entries.
    localparam int PL  = 4;
    localparam int PAT = 13;
    int ovl  [3] = '{1, 0, 1};
    int cmax [3] = '{255, 255, 7};
    int unsigned win [3][$];
    int m_match [3];
    int m_hit   [3];
    int m_evv   [3];
    int m_evc   [3];
    int m_drop  [3];

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            win[k].delete();
            m_match[k] = 0; m_hit[k] = 0; m_evv[k] = 0; m_evc[k] = 0; m_drop[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int hit, v, pop, cnt;
            hit = 0; v = 0;
            if (t_clr) begin
                win[k].delete();
                m_match[k] = 0; m_hit[k] = 0; m_evv[k] = 0; m_evc[k] = 0; m_drop[k] = 0;
                continue;
            end
            if (t_se) begin
                win[k].push_back(int'(t_z));
                if (win[k].size() > PL) void'(win[k].pop_front());
                for (int i = 0; i < win[k].size(); i++) v = v * 2 + int'(win[k][i]);
                if (win[k].size() == PL && v == PAT) hit = 1;
                if (hit && ovl[k] == 0) win[k].delete();
            end
            pop = (m_evv[k] != 0 && t_rdy) ? 1 : 0;
            cnt = (hit && m_hit[k] < cmax[k]) ? m_hit[k] + 1 : m_hit[k];
            if (hit) begin
                if (!m_evv[k] || pop) begin m_evv[k] = 1; m_evc[k] = cnt; end
                else m_drop[k] = 1;
            end else if (pop) m_evv[k] = 0;
            m_hit[k]   = cnt;
            m_match[k] = hit;
        end
    endtask

    task automatic cyc(input logic z, input logic se, input logic clr, input logic rdy);
        t_z = z; t_se = se; t_clr = clr; t_rdy = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        t_z = 0; t_se = 0; t_clr = 0; t_rdy = 0;
        reset = 1'b0;
        #1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (a_match[k] !== 1'b0 || a_evv[k] !== 1'b0 || a_drop[k] !== 1'b0 ||
                a_hit[k] !== 8'd0 || a_evc[k] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got m=%b v=%b d=%b h=%0d e=%0d exp all 0",
                         k, a_match[k], a_evv[k], a_drop[k], a_hit[k], a_evc[k]);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] p = 4'b1101;
        do_reset();
        for (int i = 3; i >= 0; i--) cyc(p[i], 1, 0, 1);
        n_chk++;
        if (a_match[0] !== 1'b1 || a_hit[0] !== 8'd1 || a_evv[0] !== 1'b1 || a_evc[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL single_hit got m=%b h=%0d v=%b e=%0d exp 1 1 1 1", a_match[0], a_hit[0], a_evv[0], a_evc[0]);
        end
        cyc(0, 0, 0, 1);
        n_chk++;
        if (a_match[0] !== 1'b0 || a_evv[0] !== 1'b0 || a_hit[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL single_after got m=%b v=%b h=%0d exp 0 0 1", a_match[0], a_evv[0], a_hit[0]);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1101101;
        int pos_a [$];
        int cnt_b = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(s[6-i], 1, 0, 1);
            if (a_match[0] === 1'b1) pos_a.push_back(i);
            if (a_match[1] === 1'b1) cnt_b++;
        end
        n_chk++;
        if (pos_a.size() != 2 || pos_a[0] != 3 || pos_a[1] != 6 || a_hit[0] !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap1 got pulses=%0d hit=%0d exp pulses=2 at 3,6 hit=2", pos_a.size(), a_hit[0]);
        end
        n_chk++;
        if (cnt_b != 1 || a_hit[1] !== 8'd1) begin
            n_fail++;
            $display("FAIL overlap0 got pulses=%0d hit=%0d exp 1 1", cnt_b, a_hit[1]);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] p = 4'b1101;
        int pulses = 0;
        int good = 0;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            cyc(p[i], 1, 0, 1);
            if (a_match[0] === 1'b1) begin pulses++; if (i == 0) good = 1; end
            cyc(1'($urandom_range(0, 1)), 0, 0, 1);
            if (a_match[0] === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses != 1 || good != 1 || a_hit[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL gapped got pulses=%0d on_time=%0d hit=%0d exp 1 1 1", pulses, good, a_hit[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s = 8'b11011101;
        do_reset();
        for (int i = 7; i >= 0; i--) cyc(s[i], 1, 0, 0);
        n_chk++;
        if (a_evv[1] !== 1'b1 || a_evc[1] !== 8'd1 || a_drop[1] !== 1'b1 || a_hit[1] !== 8'd2) begin
            n_fail++;
            $display("FAIL backpressure got v=%b e=%0d d=%b h=%0d exp 1 1 1 2", a_evv[1], a_evc[1], a_drop[1], a_hit[1]);
        end
        cyc(0, 0, 0, 1);
        n_chk++;
        if (a_evv[1] !== 1'b0 || a_drop[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop got v=%b d=%b exp 0 1", a_evv[1], a_drop[1]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        cyc(1, 1, 0, 1);
        for (int m = 1; m <= 9; m++) begin
            int e;
            e = (m < 7) ? m : 7;
            cyc(1, 1, 0, 1); cyc(0, 1, 0, 1); cyc(1, 1, 0, 1);
            n_chk++;
            if (a_match[2] !== 1'b1 || a_hit[2] !== 8'(e) || a_evv[2] !== 1'b1 || a_evc[2] !== 8'(e)) begin
                n_fail++;
                $display("FAIL saturate m=%0d got match=%b h=%0d v=%b e=%0d exp 1 %0d 1 %0d",
                         m, a_match[2], a_hit[2], a_evv[2], a_evc[2], e, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] p = 4'b1101;
        do_reset();
        for (int i = 3; i >= 0; i--) cyc(p[i], 1, 0, 0);
        cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 1, 0, 0);
        reset = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (a_match[k] !== 1'b0 || a_evv[k] !== 1'b0 || a_drop[k] !== 1'b0 ||
                a_hit[k] !== 8'd0 || a_evc[k] !== 8'd0) begin
                n_fail++;
                $display("FAIL async_reset k=%0d got m=%b v=%b d=%b h=%0d e=%0d exp all 0",
                         k, a_match[k], a_evv[k], a_drop[k], a_hit[k], a_evc[k]);
            end
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        cyc(1, 1, 0, 1);
        n_chk++;
        if (a_match !== 3'b000) begin
            n_fail++;
            $display("FAIL partial_discard got match=%b exp 000", a_match);
        end
        cyc(1, 1, 0, 1); cyc(0, 1, 0, 1); cyc(1, 1, 0, 1);
        n_chk++;
        if (a_match !== 3'b111) begin
            n_fail++;
            $display("FAIL fresh_match got match=%b exp 111", a_match);
        end
        do_reset();
        cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(0, 1, 0, 1);
        cyc(1, 1, 1, 1);
        n_chk++;
        if (a_match !== 3'b000 || a_hit[0] !== 8'd0 || a_hit[1] !== 8'd0 || a_evv !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_on_hit got match=%b h0=%0d h1=%0d v=%b exp 000 0 0 000",
                     a_match, a_hit[0], a_hit[1], a_evv);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0);
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (a_match[k] !== 1'(m_match[k]) || a_hit[k] !== 8'(m_hit[k]) ||
                    a_evv[k] !== 1'(m_evv[k]) || a_evc[k] !== 8'(m_evc[k]) ||
                    a_drop[k] !== 1'(m_drop[k])) begin
                    n_fail++;
                    if (bad < 10)
                        $display("FAIL random k=%0d n=%0d got m=%b h=%0d v=%b e=%0d d=%b exp m=%0d h=%0d v=%0d e=%0d d=%0d",
                                 k, n, a_match[k], a_hit[k], a_evv[k], a_evc[k], a_drop[k],
                                 m_match[k], m_hit[k], m_evv[k], m_evc[k], m_drop[k]);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        t_z = 0; t_se = 0; t_clr = 0; t_rdy = 0;
        #2;
        test_reset();
        test_single();
        test_overlap();
        test_gaps();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
